// File: rtl/dt_scanner_if.sv
// dt_scanner_if: display-controller bus.
//   value      [4*DIGITS-1:0]  value to show, digit 0 = least significant nibble
//   load                       one-cycle strobe capturing value
//   blank_lz                   leading-zero blanking enable
//   num        [3:0]           nibble sent to the shared dt_encoder
//   dt         [0:6]           segment pattern returned by dt_encoder
//   seg        [0:6]           registered segment drive, active-high
//   sel        [DIGITS-1:0]    registered one-hot digit enable, active-high
//   pending                    a loaded value waits for the next frame boundary
//   frame_done                 one-cycle pulse per frame wrap
// slave = dt_scanner side, master = system/encoder side.
interface dt_scanner_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                blank_lz;
  logic [3:0]          num;
  logic [0:6]          dt;
  logic [0:6]          seg;
  logic [DIGITS-1:0]   sel;
  logic                pending;
  logic                frame_done;

  modport slave (
    input  value, load, blank_lz, dt,
    output num, seg, sel, pending, frame_done
  );

  modport master (
    output value, load, blank_lz, dt,
    input  num, seg, sel, pending, frame_done
  );
endinterface

// File: rtl/dt_scanner.sv
// dt_scanner: time-multiplexed seven-segment controller sharing one dt_encoder
// across DIGITS digits. Each digit slot lasts SCAN_DIV cycles. Loaded values
// are staged and committed only at frame wrap so a frame never mixes values.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    dt_scanner_if.slave (value/load/blank_lz/dt in; num/seg/sel/
//          pending/frame_done out)
module dt_scanner #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic           clk,
  input  logic           reset,
  dt_scanner_if.slave    bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] staging_q;
  logic [4*DIGITS-1:0] shadow_q;
  logic                pending_q;
  logic                frame_done_q;
  logic [DIGITS-1:0]   sel_q;
  logic [0:6]          seg_q;

  logic                tick;
  logic                wrap;
  logic                blank;
  logic [4*DIGITS-1:0] upper;
  logic [DIGITS-1:0]   sel_d;
  logic [0:6]          seg_d;

  always_comb begin
    tick  = (cnt_q == CW'(SCAN_DIV - 1));
    wrap  = tick && (idx_q == IW'(DIGITS - 1));
    // Shadow shifted down to the current digit: low nibble is the digit,
    // all-zero means this and every higher digit is zero.
    upper = shadow_q >> {idx_q, 2'b00};
    blank = bus.blank_lz && (idx_q != '0) && (upper == '0);
    sel_d = DIGITS'(1) << idx_q;
    seg_d = blank ? '0 : bus.dt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      staging_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sel_q        <= '0;
      seg_q        <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        idx_q <= wrap ? '0 : idx_q + 1'b1;
      end

      frame_done_q <= wrap;
      if (wrap) begin
        // A load coinciding with the wrap goes straight to the display.
        if (bus.load) begin
          shadow_q  <= bus.value;
          staging_q <= bus.value;
          pending_q <= 1'b0;
        end else if (pending_q) begin
          shadow_q  <= staging_q;
          pending_q <= 1'b0;
        end
      end else if (bus.load) begin
        staging_q <= bus.value;
        pending_q <= 1'b1;
      end

      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign bus.num        = upper[3:0];
  assign bus.seg        = seg_q;
  assign bus.sel        = sel_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: doc/dt_scanner.md
# dt_scanner

Time-multiplexed display controller that shares one `dt_encoder` among up to 8 seven-segment digits. It shows a 4·DIGITS-bit value, typically a PC or register value from the MIPS core. It steps the shared encoder through one nibble per digit slot and registers the encoder result together with a one-hot digit select. New values are committed only at frame boundaries, so a frame never shows digits from two different values. Leading-zero blanking is optional.

## Interface
- `DIGITS`, default 8: number of digits, legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles per digit slot, minimum 2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `value` input 4·DIGITS: value to display; digit 0 is the least significant nibble.
- `load` input 1: single-cycle strobe that captures `value` into the staging register.
- `blank_lz` input 1: when high, leading-zero digits are blanked.
- `num` output 4: nibble driven to the shared `dt_encoder`, combinational from `shadow` and `idx`.
- `dt` input 7 [0:6]: segment pattern returned by `dt_encoder`.
- `seg` output 7 [0:6]: registered segment drive, active-high.
- `sel` output DIGITS: registered one-hot digit enable, active-high.
- `pending` output 1: a loaded value is waiting for the next frame boundary.
- `frame_done` output 1: one-cycle pulse on every frame wrap.

## Operation
- **Prescaler `cnt`** (0..SCAN_DIV-1):
  - Increments every cycle and wraps to 0.
  - `tick` = (`cnt` == SCAN_DIV-1).
- **Digit index `idx`** (0..DIGITS-1):
  - Advances by 1 on `tick`.
  - `wrap` = `tick` and `idx` == DIGITS-1; on `wrap`, `idx` returns to 0.
- **`num`** = `shadow[4·idx+3 : 4·idx]`.
- **Load path:**
  - `load` writes `staging` <= `value` and sets `pending`.
  - A repeated `load` while `pending` is set overwrites `staging`; the last value wins.
- **Commit on `wrap`:**
  - If `pending` is set, `shadow` <= `staging`, `pending` <= 0.
  - `frame_done` <= 1 for one cycle.
- **`load` in the same cycle as `wrap`:**
  - `shadow` <= `value` directly, bypassing `staging`.
  - `staging` <= `value`; `pending` stays 0.
- **Blanking:**
  - A digit is blanked when `blank_lz` = 1, `idx` != 0, and every nibble of `shadow` at positions >= `idx` is zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- **Output register, every cycle:**
  - `sel` <= onehot(`idx`).
  - `seg` <= blanked ? 7'b0000000 : `dt`.
  - A blanked digit still asserts `sel`.
- **Reset values:**
  - `cnt`, `idx`, `staging`, `shadow` = 0.
  - `pending`, `frame_done` = 0.
  - `sel` = all zeros (display off); `seg` = 0.
- **Reset mid-frame:** all state returns to the reset values immediately; a pending load is discarded.

## Timing
- `sel` and `seg` lag `idx` by exactly 1 cycle. The encoder path is combinational within that cycle.
- Slot length is SCAN_DIV cycles; frame length is DIGITS·SCAN_DIV cycles.
- The first cycle after reset deasserts shows `sel` = onehot(0) and `seg` = the encoding of `shadow` nibble 0. With `shadow` = 0, that is 7'b1111110.
- `idx` changes on the edge after the `tick` cycle, and `sel` changes one edge later.
- `frame_done` is high during the cycle after the `wrap` edge, which is the same cycle `idx` becomes 0.
- Committed `shadow` first appears on `seg` one cycle after the commit edge, in digit slot 0.
- Worst-case latency from `load` to display is DIGITS·SCAN_DIV + 1 cycles.
- Changes on `blank_lz` take effect on the next cycle's `seg` with no frame synchronisation.

## Test plan
- **Reset state:** assert `reset` mid-frame while `pending` = 1.
  - During reset: `sel` = 0, `seg` = 0, `pending` = 0.
  - After release: `sel` = 8'h01, `seg` = 7'b1111110.
- **Full scan** (SCAN_DIV = 4, DIGITS = 8, `shadow` = 32'h76543210):
  - `sel` walks 01, 02, 04 … 80, 4 cycles each.
  - `num` follows 0..7.
  - `frame_done` pulses every 32 cycles.
- **Frame-aligned commit:** `load` 32'hDEADBEEF in slot 3.
  - `pending` = 1 until the `wrap`; display unchanged until then.
  - Digit 0 then shows nibble F: `seg` = 7'b1000111.
- **Last-wins and bypass:**
  - Two `load`s in one frame (32'h1, then 32'h2): only 32'h2 is displayed.
  - `load` coincident with `wrap`: the value shows in that same frame and `pending` stays 0.
- **Leading-zero blanking** (`blank_lz` = 1, value 32'h00000A05):
  - Digits 3..7 give `seg` = 0 with `sel` still asserted.
  - Digit 1 shows "0" (7'b1111110); digit 2 shows "A" (7'b1110111).
  - Value 0: only digit 0 is lit.
- **Parameter corner** (DIGITS = 1, SCAN_DIV = 2):
  - `sel` is held at 1'b1.
  - `wrap` occurs every 2 cycles, and `frame_done` pulses every 2 cycles.
